// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler and scoreboard for the 32x32 integer register file.
// NREQ writeback requesters share the single file write port through a
// round-robin arbiter. The winner's rd/data become a registered one-cycle
// write command, and the file commits it on the following edge. A 32-entry
// busy scoreboard stalls the issue stage on RAW/WAW hazards until the pending
// write has actually landed in the file.
module rf_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [5*NREQ-1:0]    req_rd_i,
  input  logic [XLEN*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [4:0]           RD_o,
  output logic [XLEN-1:0]      WR_o,
  output logic                 RWR_EN_o,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 issue_we_i,
  input  logic [4:0]           issue_rs1_i,
  input  logic [4:0]           issue_rs2_i,
  input  logic                 issue_use_rs1_i,
  input  logic                 issue_use_rs2_i,
  output logic                 issue_stall_o,
  input  logic                 flush_i,
  output logic [31:0]          busy_o
);

  // Pointer width; NREQ >= 2 keeps this at least 1.
  localparam int PW = $clog2(NREQ);

  // Per-requester views of the packed request buses.
  logic [4:0]      req_rd_arr   [NREQ];
  logic [XLEN-1:0] req_data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_rd_arr[gi]   = req_rd_i[gi*5 +: 5];
      assign req_data_arr[gi] = req_data_i[gi*XLEN +: XLEN];
    end
  endgenerate

  // Arbiter state and decision.
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   rr_ptr_next;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [PW:0]     cand;

  // Write command registers.
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] wr_reg;
  logic            wen_reg;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // Scoreboard.
  logic [31:0]     busy_reg;
  logic [31:0]     busy_next;
  logic            raw_hazard;
  logic            waw_hazard;
  logic            issue_stall;
  logic            issue_fire;

  // Round-robin search: walk the requesters starting at rr_ptr, wrapping mod NREQ.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_reg} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!grant_any && req_valid_i[cand[PW-1:0]]) begin
        grant[cand[PW-1:0]] = 1'b1;
        grant_idx           = cand[PW-1:0];
        grant_any           = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      if (grant_idx == PW'(NREQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = grant_idx + PW'(1);
      end
    end
  end

  // One-hot AND-OR mux selecting the winner's destination and result.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_rd   = req_rd_arr[k];
        sel_data = req_data_arr[k];
      end
    end
  end

  // Grants are suppressed while reset is asserted so nothing is accepted then.
  assign req_ready_o = rst_ni ? grant : '0;

  // Register the arbitration pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Write command: pulse enable for one cycle per grant; address/data hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_reg  <= '0;
      wr_reg  <= '0;
      wen_reg <= 1'b0;
    end else begin
      wen_reg <= grant_any;
      if (grant_any) begin
        rd_reg <= sel_rd;
        wr_reg <= sel_data;
      end
    end
  end

  assign RD_o     = rd_reg;
  assign WR_o     = wr_reg;
  assign RWR_EN_o = wen_reg;

  // Hazard detection against the current scoreboard; no bypass from the
  // write that is in flight this cycle, so it releases one cycle later.
  always_comb begin
    raw_hazard  = (issue_use_rs1_i & busy_reg[issue_rs1_i]) |
                  (issue_use_rs2_i & busy_reg[issue_rs2_i]);
    waw_hazard  = issue_we_i & busy_reg[issue_rd_i];
    issue_stall = issue_valid_i & (raw_hazard | waw_hazard | flush_i);
    issue_fire  = issue_valid_i & ~issue_stall & issue_we_i & (issue_rd_i != 5'd0);
  end

  assign issue_stall_o = issue_stall;

  // Scoreboard next state: clear when the write reaches the file, then let a
  // new producer's set override it; flush wipes everything; x0 never busy.
  always_comb begin
    busy_next = busy_reg;
    if (flush_i) begin
      busy_next = '0;
    end else begin
      if (wen_reg && (rd_reg != 5'd0)) begin
        busy_next[rd_reg] = 1'b0;
      end
      if (issue_fire) begin
        busy_next[issue_rd_i] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Register the scoreboard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_o = busy_reg;

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Write-port scheduler and scoreboard for the 32x32 integer register file. It shares the file's single write port between NREQ writeback requesters (ALU, load unit, JAL/U-type unit) using round-robin arbitration. It drives the registered RD/WR/RWR_EN write command into the register file. It also keeps per-register busy bits, so the issue stage stalls on RAW/WAW hazards until the pending write has landed in the file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous reset, active-low
req_valid_i  in  NREQ  requester k has a result
req_rd_i  in  5*NREQ  destination register of requester k (slice k)
req_data_i  in  XLEN*NREQ  result of requester k (slice k)
req_ready_o  out  NREQ  one-hot grant; request k accepted when valid&ready
RD_o  out  5  register-file write address
WR_o  out  XLEN  register-file write data
RWR_EN_o  out  1  register-file write enable, one-cycle pulse per accepted request
issue_valid_i  in  1  issue stage presents an instruction
issue_rd_i  in  5  its destination register
issue_we_i  in  1  instruction writes rd
issue_rs1_i  in  5  source 1
issue_rs2_i  in  5  source 2
issue_use_rs1_i  in  1  rs1 is read
issue_use_rs2_i  in  1  rs2 is read
issue_stall_o  out  1  hazard; issue must hold
flush_i  in  1  pipeline flush; clears scoreboard
busy_o  out  32  scoreboard bits, bit 0 always 0

Behaviour:
- Reset (rst_ni low, asynchronous): RWR_EN_o=0, RD_o=0, WR_o=0, busy=0, rr_ptr=0. req_ready_o=0 while in reset.
- Arbitration (combinational): search from rr_ptr upward, mod NREQ. The first k with req_valid_i[k] gets req_ready_o[k]=1; all other bits are 0. At most one grant per cycle. There is no back-pressure from the file, so any valid request is granted within NREQ cycles.
- rr_ptr update: on a grant to k, rr_ptr <= (k+1) mod NREQ. With no grant, rr_ptr holds.
- Write command: on the edge ending the grant cycle T, RD_o <= req_rd_i[k], WR_o <= req_data_i[k], RWR_EN_o <= 1. With no grant, RWR_EN_o <= 0 and RD_o/WR_o hold. The file writes on the following edge, end of T+1.
- Writes with rd=0 are arbitrated and pulsed normally. The file discards them, and they never touch busy.
- Scoreboard set: issue_fire = issue_valid_i & ~issue_stall_o & issue_we_i & (issue_rd_i!=0). On issue_fire, busy[issue_rd_i] <= 1.
- Scoreboard clear: when RWR_EN_o=1 and RD_o!=0, busy[RD_o] <= 0 at the end of that cycle, i.e. when the data reaches the file. Clearing on grant is not allowed, because the file read would still be stale.
- Same register set and cleared on one edge: the set wins, because the new producer owns rd.
- Stall (combinational):
  - issue_stall_o = issue_valid_i & (RAW | WAW | flush_i).
  - RAW = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]).
  - WAW = we & busy[rd].
  - Busy bit 0 is hardwired 0, so x0 operands never stall.
  - There is no forwarding from the in-flight RWR_EN_o write: a register being written this cycle still stalls, and the stall releases next cycle.
- Flush: flush_i=1 clears all busy bits at the edge and blocks issue_fire that cycle. Arbitration and the in-flight write command are unaffected; requesters are responsible for squashing their own results.
- Requester rules: req_rd_i and req_data_i must stay stable while valid and not ready. The scheduler does not check requester rd against busy.

Test Plan:
- Reset mid-operation: drop rst_ni asynchronously while RWR_EN_o=1 and busy[5]=1. Outputs go to 0 immediately. After release, a req_valid_i=3'b111 grants req 0 first.
- Round-robin: hold req_valid_i=3'b111 for 6 cycles. Grants are 001,010,100,001,010,100, and RWR_EN_o pulses each cycle with RD/WR lagging the grant by 1 cycle. Then req_valid_i=3'b100 with rr_ptr=0 grants req 2 immediately.
- RAW timing: issue rd=7 (busy[7]=1). Next cycle, issue rs1=7 is stalled. Req 1 writes rd=7 data 0xDEADBEEF granted at T. Stall persists through T+1 and drops at T+2, when the file holds 0xDEADBEEF.
- Simultaneous set/clear: RWR_EN_o clearing rd=9 on the same edge as issue_fire with rd=9. busy[9] stays 1.
- x0 handling: request rd=0 data 0x1234 pulses RWR_EN_o with RD_o=0 and busy unchanged. Issue with rs1=0/rd=0 never stalls.
- Flush: busy=0x0000_0C80 and flush_i=1 with an issue_valid_i present. Issue stalls that cycle, busy_o=0 next cycle, and a concurrently granted write still pulses RWR_EN_o.
